// File: rtl/booth_seq_divider.sv
// booth_seq_divider: sequential signed restoring divider with start/done handshake
module booth_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [WIDTH:0] a, am;
  logic [WIDTH-1:0] b, bm, dvd, t, diff;
  logic [WIDTH-2:0] r;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, dz, ov, ge;
  always_comb begin
    am = dividend[WIDTH-1] ? -{1'b1, dividend} : {1'b0, dividend};
    bm = divisor[WIDTH-1] ? -divisor : divisor;
    t = {r, a[WIDTH]};
    ge = t >= b;
    diff = t - b;
  end
  // The partial remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH-1 bits hold it;
  // the WIDTH+1-bit dividend magnitude is shifted out fully, one extra step per operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {a, b, r, dvd, cnt, neg_q, neg_r, dz, ov} <= '0;
      {quotient, remainder, busy, done, div_by_zero, overflow} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a <= am;
          b <= bm;
          r <= '0;
          dvd <= dividend;
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
          dz <= divisor == '0;
          ov <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
          cnt <= '0;
          busy <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          r <= ge ? diff[WIDTH-2:0] : t[WIDTH-2:0];
          a <= {a[WIDTH-1:0], ge};
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(WIDTH) ? FIX : CALC;
        end
        FIX: begin
          quotient <= dz ? '1 : neg_q ? -a[WIDTH-1:0] : a[WIDTH-1:0];
          remainder <= dz ? dvd : neg_r ? -{1'b0, r} : {1'b0, r};
          div_by_zero <= dz;
          overflow <= ov;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_divider.sv
// tb_booth_seq_divider: randomized scoreboard bench for booth_seq_divider
module tb_booth_seq_divider;
  localparam int W = 4;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic busy, done, div_by_zero, overflow;
  booth_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [W-1:0] q, r;
    logic dz, ov;
    int due;
  } exp_t;
  exp_t sbq[$];
  exp_t m_e;
  int ntests = 0, nfail = 0;
  task automatic chk(string name, int act, int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic exp_t model(int x, int y);
    exp_t e;
    int mn = -(1 << (W - 1));
    int q, rr;
    e.dz = (y == 0);
    e.ov = (x == mn && y == -1);
    q = e.dz ? -1 : e.ov ? mn : x / y;
    rr = e.dz ? x : e.ov ? 0 : x % y;
    e.q = W'(q);
    e.r = W'(rr);
    e.due = 0;
    return e;
  endfunction
  task automatic wait_idle();
    int i = 0;
    while (busy && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask
  task automatic push(int x, int y);
    exp_t e = model(x, y);
    e.due = cyc + W + 2;
    sbq.push_back(e);
  endtask
  task automatic issue(int x, int y);
    wait_idle();
    dividend = W'(x);
    divisor = W'(y);
    start = 1;
    @(posedge clk);
    #1;
    push(x, y);
    start = 0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done_expected", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        m_e = sbq.pop_front();
        chk("quotient", quotient, m_e.q);
        chk("remainder", remainder, m_e.r);
        chk("div_by_zero", div_by_zero, m_e.dz);
        chk("overflow", overflow, m_e.ov);
        chk("latency_cycle", cyc, m_e.due);
      end
    end
  end
  initial begin
    int i;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    rst = 0;
    @(negedge clk);
    issue(7, 2);
    issue(3, 5);
    issue(-7, 2);
    issue(7, -2);
    issue(-7, -2);
    issue(-8, -1);
    issue(-8, 1);
    issue(5, 0);
    issue(6, 3);
    // extra starts during an operation must be ignored
    issue(6, 4);
    dividend = 4'd1;
    divisor = 4'd1;
    start = 1;
    repeat (2) @(negedge clk);
    start = 0;
    // start held high across done launches a second operation right away
    wait_idle();
    dividend = 4'd6;
    divisor = 4'd3;
    start = 1;
    @(posedge clk);
    #1;
    push(6, 3);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < 40);
    chk("held_start_done_seen", done, 1);
    @(posedge clk);
    #1;
    push(6, 3);
    @(negedge clk);
    start = 0;
    chk("held_start_busy", busy, 1);
    // reset in the middle of a calculation
    issue(7, 2);
    wait_idle();
    dividend = 4'd6;
    divisor = 4'd4;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    rst = 0;
    issue(-7, 2);
    for (int k = 0; k < 150; k++) begin
      issue(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
